// File: rtl/keypad_event_encoder_pkg.sv
// Shared definitions for the keypad event encoder slice.
//   - Key code constants for the non-digit buttons.
//   - Press FSM state encoding.
//   - Helpers that classify and encode a debounced pad state.
package keypad_event_encoder_pkg;

  localparam logic [3:0] KEY_DIV_MOD    = 4'hA;
  localparam logic [3:0] KEY_TIMES      = 4'hB;
  localparam logic [3:0] KEY_PLUS_MINUS = 4'hC;
  localparam logic [3:0] KEY_CLEAR      = 4'hD;
  localparam logic [3:0] KEY_ANS        = 4'hE;
  localparam logic [3:0] KEY_EQU        = 4'hF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHeld = 2'd1,
    StLock = 2'd2
  } press_state_e;

  // True when exactly one button is down.
  function automatic logic is_single_key(input logic [15:0] pad);
    return (pad != 16'h0000) && ((pad & (pad - 16'h0001)) == 16'h0000);
  endfunction

  // Index of the set bit; only meaningful when is_single_key(pad) holds.
  function automatic logic [3:0] key_index(input logic [15:0] pad);
    logic [3:0] idx;
    idx = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pad[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_event_encoder_if.sv
// Key event channel between the keypad front-end and the calculator buffer logic.
//   key_valid  head entry present (FWFT)
//   key_ready  consumer accepts the head entry this cycle
//   key_code   head entry code, valid whenever key_valid=1
//   clr_pulse  one-cycle pulse per accepted clear-key press
//   overflow   sticky: a press was dropped because the queue was full
// master: the encoder side; slave: the consumer side.
interface keypad_event_encoder_if;
  import keypad_event_encoder_pkg::*;

  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_code;
  logic       clr_pulse;
  logic       overflow;

  modport master (
    output key_valid,
    output key_code,
    output clr_pulse,
    output overflow,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  clr_pulse,
    input  overflow,
    output key_ready
  );

endinterface

// File: rtl/keypad_event_encoder_key_fifo.sv
// First-word fall-through key-code queue.
//   clk_i        clock
//   rst_i        asynchronous reset, active-high
//   push_i       write push_data_i (dropped if full and not popping)
//   push_data_i  entry to enqueue
//   pop_ready_i  consumer accepts the head entry; ignored while empty
//   valid_o      queue not empty
//   head_data_o  head entry, 0 while empty
//   overflow_o   sticky drop flag, cleared only by reset
// Depth must be a power of two >= 2 so the pointers wrap naturally.
module keypad_event_encoder_key_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_ready_i,
  output logic             valid_o,
  output logic [Width-1:0] head_data_o,
  output logic             overflow_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, pop, push_acc;

  always_comb begin
    valid_o    = (count_q != '0);
    full       = (count_q == CntW'(Depth));
    pop        = valid_o & pop_ready_i;
    // A pop in the same cycle frees the slot the push needs.
    push_acc   = push_i & (~full | pop);
    overflow_d = overflow_q | (push_i & full & ~pop);
    wptr_d     = push_acc ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d     = pop ? rptr_q + PtrW'(1) : rptr_q;
    count_d    = count_q + CntW'(push_acc) - CntW'(pop);
    head_data_o = valid_o ? mem_q[rptr_q] : '0;
    overflow_o  = overflow_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: reads are masked by valid_o.
  always_ff @(posedge clk_i) begin
    if (push_acc) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/keypad_event_encoder.sv
// Keypad front-end: synchronises and debounces the 16-button pad, turns each clean
// single-key press into a 4-bit code queued for the consumer, and reports the clear
// key as a one-cycle pulse outside the queue.
//   clock_50m  board clock, only clock
//   rst        asynchronous reset, active-high
//   pb         raw push-buttons, 1 = pressed, asynchronous
//   key_if     master side of the key event channel (valid/ready, code, clr, overflow)
module keypad_event_encoder
  import keypad_event_encoder_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 2**17,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                  clock_50m,
  input  logic                  rst,
  input  logic [15:0]           pb,
  keypad_event_encoder_if.master key_if
);

  localparam int unsigned TickW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned StableW = $clog2(DEBOUNCE_TICKS + 1);

  logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
  logic               tick;
  logic [15:0]        sync1_q, sync2_q;
  logic [15:0]        last_sample_q, last_sample_d;
  logic [StableW-1:0] stable_cnt_q, stable_cnt_d;
  logic [15:0]        deb_state_q, deb_state_d;
  logic               deb_upd, deb_upd_q;
  press_state_e       state_q, state_d;
  logic               emit;
  logic [3:0]         emit_code;
  logic               key_push;
  logic               clr_pulse_q, clr_pulse_d;

  // Sample strobe.
  always_comb begin
    tick       = (tick_cnt_q == TickW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
  end

  // Debounce: accept a pad state once it has been seen on DEBOUNCE_TICKS further ticks.
  always_comb begin
    last_sample_d = last_sample_q;
    stable_cnt_d  = stable_cnt_q;
    deb_state_d   = deb_state_q;
    deb_upd       = 1'b0;
    if (tick) begin
      if (sync2_q == last_sample_q) begin
        if (stable_cnt_q != StableW'(DEBOUNCE_TICKS)) begin
          stable_cnt_d = stable_cnt_q + StableW'(1);
        end
        // Update only on the tick the count reaches the threshold, not while saturated.
        if (stable_cnt_q == StableW'(DEBOUNCE_TICKS - 1)) begin
          deb_state_d = last_sample_q;
          deb_upd     = 1'b1;
        end
      end else begin
        stable_cnt_d  = '0;
        last_sample_d = sync2_q;
      end
    end
  end

  // Press FSM, evaluated the cycle after each debounced-state update.
  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_code = key_index(deb_state_q);
    if (deb_upd_q) begin
      case (state_q)
        StIdle: begin
          if (is_single_key(deb_state_q)) begin
            emit    = 1'b1;
            state_d = StHeld;
          end else if (deb_state_q != 16'h0000) begin
            state_d = StLock;
          end
        end
        StHeld, StLock: begin
          if (deb_state_q == 16'h0000) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
    key_push    = emit & (emit_code != KEY_CLEAR);
    clr_pulse_d = emit & (emit_code == KEY_CLEAR);
  end

  always_ff @(posedge clock_50m or posedge rst) begin
    if (rst) begin
      tick_cnt_q    <= '0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      last_sample_q <= '0;
      stable_cnt_q  <= '0;
      deb_state_q   <= '0;
      deb_upd_q     <= 1'b0;
      state_q       <= StIdle;
      clr_pulse_q   <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      sync1_q       <= pb;
      sync2_q       <= sync1_q;
      last_sample_q <= last_sample_d;
      stable_cnt_q  <= stable_cnt_d;
      deb_state_q   <= deb_state_d;
      deb_upd_q     <= deb_upd;
      state_q       <= state_d;
      clr_pulse_q   <= clr_pulse_d;
    end
  end

  assign key_if.clr_pulse = clr_pulse_q;

  keypad_event_encoder_key_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (4)
  ) u_key_fifo (
    .clk_i       (clock_50m),
    .rst_i       (rst),
    .push_i      (key_push),
    .push_data_i (emit_code),
    .pop_ready_i (key_if.key_ready),
    .valid_o     (key_if.key_valid),
    .head_data_o (key_if.key_code),
    .overflow_o  (key_if.overflow)
  );

endmodule
